// File: rtl/ens_vote_argmax.sv
// ens_vote_argmax: accumulates per-class codes from NUM_MEMBERS ensemble
// beats, then scans the classes one per cycle for the argmax.
// The winning index and its score are held on a valid/ready output.
// Optional macro ENS_VOTE_TIE_FLAG_EN adds out_tie.
// out_tie reports that another class matched the winning score.
module ens_vote_argmax #(
   parameter int NUM_CLASSES = 10,
   parameter int OUT_BITS    = 2,
   parameter int NUM_MEMBERS = 4,
   parameter int ACC_W       = 6,
   parameter int CLS_W       = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [NUM_CLASSES*OUT_BITS-1:0] in_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [CLS_W-1:0]                out_class,
   output logic [ACC_W-1:0]                out_score
`ifdef ENS_VOTE_TIE_FLAG_EN
   ,
   output logic                            out_tie
`endif
);

   localparam int CNT_W = $clog2(NUM_MEMBERS + 1);

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_SCAN  = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [ACC_W-1:0]   acc_q [NUM_CLASSES];
   logic [ACC_W-1:0]   acc_d [NUM_CLASSES];
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [CLS_W-1:0]   scan_q, scan_d;
   logic [CLS_W-1:0]   best_idx_q, best_idx_d;
   logic [ACC_W-1:0]   best_score_q, best_score_d;
   logic [CLS_W-1:0]   out_class_q, out_class_d;
   logic [ACC_W-1:0]   out_score_q, out_score_d;

   logic               accept;
   logic               accum_done;
   logic [ACC_W-1:0]   scan_val;
   logic               scan_gt;
   logic               scan_last;

   assign in_ready   = (state_q == ST_ACCUM) && !rst;
   assign out_valid  = (state_q == ST_HOLD);
   assign out_class  = out_class_q;
   assign out_score  = out_score_q;

   assign accept     = in_valid && in_ready;
   assign accum_done = accept && (cnt_q == CNT_W'(NUM_MEMBERS - 1));
   assign scan_val   = acc_q[scan_q];
   assign scan_gt    = scan_val > best_score_q;
   assign scan_last  = (scan_q == CLS_W'(NUM_CLASSES - 1));

   // Next-state logic: accumulate beats, scan for argmax, hold the result.
   always_comb begin
      state_d      = state_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      scan_d       = scan_q;
      best_idx_d   = best_idx_q;
      best_score_d = best_score_q;
      out_class_d  = out_class_q;
      out_score_d  = out_score_q;
      case (state_q)
         ST_ACCUM: begin
            if (accept) begin
               for (int c = 0; c < NUM_CLASSES; c++) begin
                  acc_d[c] = acc_q[c] + ACC_W'(in_data[c*OUT_BITS +: OUT_BITS]);
               end
               if (accum_done) begin
                  cnt_d        = '0;
                  best_idx_d   = '0;
                  best_score_d = acc_d[0];
                  scan_d       = CLS_W'(1);
                  state_d      = ST_SCAN;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_SCAN: begin
            // Strict compare: ties keep the lower index.
            if (scan_gt) begin
               best_idx_d   = scan_q;
               best_score_d = scan_val;
            end
            if (scan_last) begin
               out_class_d = best_idx_d;
               out_score_d = best_score_d;
               state_d     = ST_HOLD;
            end else begin
               scan_d = scan_q + CLS_W'(1);
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               for (int c = 0; c < NUM_CLASSES; c++) begin
                  acc_d[c] = '0;
               end
               state_d = ST_ACCUM;
            end
         end
         default: state_d = ST_ACCUM;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_ACCUM;
         for (int c = 0; c < NUM_CLASSES; c++) begin
            acc_q[c] <= '0;
         end
         cnt_q        <= '0;
         scan_q       <= '0;
         best_idx_q   <= '0;
         best_score_q <= '0;
         out_class_q  <= '0;
         out_score_q  <= '0;
      end else begin
         state_q      <= state_d;
         acc_q        <= acc_d;
         cnt_q        <= cnt_d;
         scan_q       <= scan_d;
         best_idx_q   <= best_idx_d;
         best_score_q <= best_score_d;
         out_class_q  <= out_class_d;
         out_score_q  <= out_score_d;
      end
   end

`ifdef ENS_VOTE_TIE_FLAG_EN
   logic tie_q, tie_d;
   logic out_tie_q, out_tie_d;
   logic scan_eq;

   assign scan_eq = (scan_val == best_score_q);
   assign out_tie = out_tie_q;

   // Tie tracking: set on an equal score, cleared when the best is replaced.
   always_comb begin
      tie_d     = tie_q;
      out_tie_d = out_tie_q;
      if (accum_done) begin
         tie_d = 1'b0;
      end else if (state_q == ST_SCAN) begin
         if (scan_gt) begin
            tie_d = 1'b0;
         end else if (scan_eq) begin
            tie_d = 1'b1;
         end
         if (scan_last) begin
            out_tie_d = tie_d;
         end
      end
   end

   // Tie flag registers, registered alongside out_class.
   always_ff @(posedge clk) begin
      if (rst) begin
         tie_q     <= 1'b0;
         out_tie_q <= 1'b0;
      end else begin
         tie_q     <= tie_d;
         out_tie_q <= out_tie_d;
      end
   end
`endif

endmodule

// File: tb/tb_ens_vote_argmax.sv
// Scoreboard bench for ens_vote_argmax: a reference model turns every
// accepted group of beats into an expected result.
// A separate monitor compares each result against that expectation when it is handed off.
module tb_ens_vote_argmax;

   localparam int NC  = 10;
   localparam int OB  = 2;
   localparam int NM  = 4;
   localparam int AW  = 6;
   localparam int CW  = 4;
   localparam int DW  = NC * OB;

   typedef struct {
      int cls;
      int score;
      int tie;
      int rise;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [CW-1:0] out_class;
   logic [AW-1:0] out_score;
`ifdef ENS_VOTE_TIE_FLAG_EN
   logic          out_tie;
`endif

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   ready_mode = 0;   // 0: always ready, 1: random, 2: held low
   exp_t sb[$];
   int   sums[NC];
   int   beats = 0;
   logic ov_prev = 1'b0;
   int   held_c = 0;
   int   held_s = 0;

   ens_vote_argmax #(
      .NUM_CLASSES(NC), .OUT_BITS(OB), .NUM_MEMBERS(NM), .ACC_W(AW), .CLS_W(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_class(out_class), .out_score(out_score)
`ifdef ENS_VOTE_TIE_FLAG_EN
      , .out_tie(out_tie)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ($urandom_range(0, 2) != 0);
         default: out_ready = 1'b0;
      endcase
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout cycle=%0d", cyc);
      $fatal(1, "watchdog");
   end

   // Reference model: sum fields, argmax by first maximum, tie if maximum repeats.
   task automatic model_clear();
      for (int c = 0; c < NC; c++) sums[c] = 0;
      beats = 0;
   endtask

   task automatic model_accept(input logic [DW-1:0] d, input int t);
      exp_t e;
      int mx, nmx, idx;
      logic [DW-1:0] dd;
      dd = d;
      for (int c = 0; c < NC; c++) sums[c] += int'(dd[c*OB +: OB]);
      beats++;
      if (beats == NM) begin
         mx = -1; idx = 0; nmx = 0;
         for (int c = 0; c < NC; c++) if (sums[c] > mx) begin mx = sums[c]; idx = c; end
         for (int c = 0; c < NC; c++) if (sums[c] == mx) nmx++;
         e.cls = idx; e.score = mx; e.tie = (nmx > 1) ? 1 : 0; e.rise = t + NC;
         sb.push_back(e);
         model_clear();
      end
   endtask

   function automatic logic [DW-1:0] fill(input int rest, input int ia, input int va,
                                           input int ib, input int vb);
      logic [DW-1:0] d;
      for (int c = 0; c < NC; c++) d[c*OB +: OB] = OB'(rest);
      if (ia >= 0) d[ia*OB +: OB] = OB'(va);
      if (ib >= 0) d[ib*OB +: OB] = OB'(vb);
      return d;
   endfunction

   // Called at posedge+1; returns at posedge+1 after the transfer.
   task automatic send_beat(input logic [DW-1:0] d);
      int w;
      logic done;
      w = 0; done = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            model_accept(d, cyc);
            done = 1'b1;
         end else if (w > 200) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout got=0 want=1 cycle=%0d", cyc);
            done = 1'b1;
         end
         w++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      sb.delete();
      model_clear();
      repeat (n) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b0 || out_class !== '0 || out_score !== '0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got=v%0b c%0d s%0d r%0b want=v0 c0 s0 r0",
                     out_valid, out_class, out_score, in_ready);
         end
`ifdef ENS_VOTE_TIE_FLAG_EN
         checks++;
         if (out_tie !== 1'b0) begin
            errors++;
            $display("FAIL reset_tie got=%0b want=0", out_tie);
         end
`endif
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_after_reset got=%0b want=1", in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_drain();
      int w;
      w = 0;
      while (sb.size() > 0 && w < 200) begin @(posedge clk); #1; w++; end
      if (sb.size() > 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout got=%0d pending want=0", sb.size());
         sb.delete();
      end
   endtask

   // Monitor: latency on rising out_valid, stability while held, compare on handshake.
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         ov_prev = 1'b0;
      end else begin
         if (out_valid) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL ready_in_hold got=%0b want=0 cycle=%0d", in_ready, cyc);
            end
            if (!ov_prev) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_result got=c%0d s%0d want=none", out_class, out_score);
               end else if (cyc != sb[0].rise) begin
                  errors++;
                  $display("FAIL latency got=%0d want=%0d", cyc, sb[0].rise);
               end
            end else begin
               checks++;
               if (int'(out_class) != held_c || int'(out_score) != held_s) begin
                  errors++;
                  $display("FAIL hold_stable got=c%0d s%0d want=c%0d s%0d",
                           out_class, out_score, held_c, held_s);
               end
            end
            held_c = int'(out_class);
            held_s = int'(out_score);
            if (out_ready && sb.size() > 0) begin
               e = sb.pop_front();
               checks++;
               if (int'(out_class) != e.cls || int'(out_score) != e.score) begin
                  errors++;
                  $display("FAIL result got=c%0d s%0d want=c%0d s%0d",
                           out_class, out_score, e.cls, e.score);
               end
`ifdef ENS_VOTE_TIE_FLAG_EN
               checks++;
               if (int'(out_tie) != e.tie) begin
                  errors++;
                  $display("FAIL tie got=%0b want=%0d", out_tie, e.tie);
               end
`endif
            end
         end
         ov_prev = out_valid;
      end
   end

   initial begin
      int w;
      model_clear();
      @(negedge clk);
      do_reset(3);

      // Basic decision: class 3 gets 3 per beat.
      repeat (NM) send_beat(fill(0, 3, 3, -1, 0));
      wait_drain();

      // Tie between classes 2 and 7 (8 each), others 4.
      repeat (NM) send_beat(fill(1, 2, 2, 7, 2));
      wait_drain();

      // All-zero input.
      repeat (NM) send_beat('0);
      wait_drain();

      // Backpressure in HOLD with in_valid driven.
      ready_mode = 2;
      @(posedge clk); #1;
      repeat (NM) send_beat(fill(0, 6, 2, 8, 1));
      w = 0;
      while (!out_valid && w < 50) begin @(negedge clk); w++; end
      checks++;
      if (!out_valid) begin
         errors++;
         $display("FAIL bp_wait got=0 want=1");
      end
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = DW'($urandom());
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL backpressure got=v%0b r%0b want=v1 r0", out_valid, in_ready);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      ready_mode = 0;
      wait_drain();
      repeat (NM) send_beat(fill(0, 9, 1, 4, 3));
      wait_drain();

      // Reset mid-accumulation, then bubbles.
      repeat (2) send_beat(fill(0, 5, 3, -1, 0));
      do_reset(1);
      for (int i = 0; i < NM; i++) begin
         send_beat(fill(0, 1, 1, -1, 0));
         idle(i % 3);
      end
      wait_drain();

      // Randomized decisions with random gaps and output backpressure.
      ready_mode = 1;
      for (int k = 0; k < 40; k++) begin
         for (int b = 0; b < NM; b++) begin
            send_beat(DW'($urandom()));
            idle($urandom_range(0, 2));
         end
      end
      ready_mode = 0;
      wait_drain();
      idle(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
